boot_run_sequencer: RTL and testbench

//  Sequences the single-cycle core from power-up to halt: streams a program into instruction

---
 rtl/boot_run_sequencer.sv | 163 ++++++++++++++++
 tb/tb_boot_run_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_run_sequencer.sv
// boot_run_sequencer: loads a program into instruction memory, holds the core in reset,
// runs it and watches the fetched instruction for a halt opcode or a cycle-budget timeout.
module boot_run_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [31:0] HALT_INSTR = 32'h00000073,
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       core_instr,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error,
    output logic [31:0]       run_cycles
);

    localparam int unsigned       HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [31:0]       TIMEOUT_W = 32'(TIMEOUT);
    localparam logic [1:0]        ERR_NONE  = 2'b00;
    localparam logic [1:0]        ERR_OVF   = 2'b01;
    localparam logic [1:0]        ERR_TO    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] word_cnt, word_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              imem_we_nxt;
    logic [ADDR_W-1:0] imem_addr_nxt;
    logic [31:0]       imem_wdata_nxt;
    logic              core_reset_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [1:0]        error_nxt;
    logic [31:0]       run_cycles_nxt;
    logic [31:0]       run_inc;
    logic              hs;

    // Loader is ready exactly while in LOAD, straight from the state register.
    assign ld_ready = (state == S_LOAD);
    assign hs       = ld_valid & ld_ready;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= ERR_NONE;
            run_cycles <= '0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            imem_we    <= imem_we_nxt;
            imem_addr  <= imem_addr_nxt;
            imem_wdata <= imem_wdata_nxt;
            core_reset <= core_reset_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            run_cycles <= run_cycles_nxt;
        end
    end

    // Next state and next values of every registered output; abort overrides everything.
    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        hold_cnt_nxt   = hold_cnt;
        imem_we_nxt    = 1'b0;
        imem_addr_nxt  = imem_addr;
        imem_wdata_nxt = imem_wdata;
        done_nxt       = done;
        error_nxt      = error;
        run_cycles_nxt = run_cycles;
        run_inc        = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;

        if (abort) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b0;
            error_nxt = ERR_NONE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_nxt    = S_LOAD;
                        done_nxt     = 1'b0;
                        error_nxt    = ERR_NONE;
                        word_cnt_nxt = '0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        imem_we_nxt    = 1'b1;
                        imem_addr_nxt  = word_cnt;
                        imem_wdata_nxt = ld_data;
                        word_cnt_nxt   = word_cnt + ADDR_W'(1);
                        if (ld_last) begin
                            state_nxt    = S_HOLD;
                            hold_cnt_nxt = '0;
                        end else if (word_cnt == ADDR_MAX) begin
                            // Memory full with more program pending: stop rather than wrap.
                            state_nxt = S_ERR;
                            error_nxt = ERR_OVF;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt      = S_RUN;
                        run_cycles_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    run_cycles_nxt = run_inc;
                    if (core_instr == HALT_INSTR) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else if ((TIMEOUT != 0) && (run_inc >= TIMEOUT_W)) begin
                        state_nxt = S_ERR;
                        error_nxt = ERR_TO;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        core_reset_nxt = (state_nxt != S_RUN);
        busy_nxt       = (state_nxt == S_LOAD) || (state_nxt == S_HOLD) || (state_nxt == S_RUN);
    end

endmodule

// File: tb/tb_boot_run_sequencer.sv
// Bench for boot_run_sequencer: scoreboarded imem writes, run/halt/timeout, overflow, abort, reset.
module tb_boot_run_sequencer;

    localparam logic [31:0] HALT = 32'h00000073;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Instance A: 256-word memory, 16-cycle timeout
    logic        start, abort, ld_valid, ld_last;
    logic [31:0] ld_data, core_instr;
    logic        a_ld_ready, a_imem_we, a_core_reset, a_busy, a_done;
    logic [7:0]  a_imem_addr;
    logic [31:0] a_imem_wdata, a_run_cycles;
    logic [1:0]  a_error;

    // Instance B: 4-word memory for the overflow case
    logic        b_start, b_abort, b_ld_valid, b_ld_last;
    logic [31:0] b_ld_data, b_core_instr;
    logic        b_ld_ready, b_imem_we, b_core_reset, b_busy, b_done;
    logic [1:0]  b_imem_addr;
    logic [31:0] b_imem_wdata, b_run_cycles;
    logic [1:0]  b_error;

    boot_run_sequencer #(.ADDR_W(8), .HALT_INSTR(HALT), .RESET_HOLD(2), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(rst), .start(start), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(a_ld_ready),
        .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
        .core_instr(core_instr), .core_reset(a_core_reset), .busy(a_busy), .done(a_done),
        .error(a_error), .run_cycles(a_run_cycles)
    );

    boot_run_sequencer #(.ADDR_W(2), .HALT_INSTR(HALT), .RESET_HOLD(2), .TIMEOUT(1024)) dut_b (
        .clk(clk), .reset(rst), .start(b_start), .abort(b_abort),
        .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last), .ld_ready(b_ld_ready),
        .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .core_instr(b_core_instr), .core_reset(b_core_reset), .busy(b_busy), .done(b_done),
        .error(b_error), .run_cycles(b_run_cycles)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    int wr_a = 0;
    int wr_b = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every imem write must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (a_imem_we === 1'b1) begin
            wr_a++;
            chk("a_wr_queued", 64'(exp_a.size() > 0), 64'd1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                chk("a_wr", {24'h0, a_imem_addr, a_imem_wdata}, e);
            end
        end
        if (b_imem_we === 1'b1) begin
            wr_b++;
            chk("b_wr_queued", 64'(exp_b.size() > 0), 64'd1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                chk("b_wr", {30'h0, b_imem_addr, b_imem_wdata}, e);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(a_busy), 64'd1);
        chk("start_ld_ready", 64'(a_ld_ready), 64'd1);
        chk("start_err_clr", 64'(a_error), 64'd0);
        chk("start_done_clr", 64'(a_done), 64'd0);
    endtask

    // Stream n words, last on the final one; optional idle cycle between words.
    task automatic load(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            chk("ld_ready_hi", 64'(a_ld_ready), 64'd1);
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = (i == n - 1);
            exp_a.push_back({24'h0, 8'(i), ld_data});
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (gap && (i != n - 1)) begin
                tick();
                chk("gap_no_we", 64'(a_imem_we), 64'd0);
            end
        end
        chk("hold_ld_ready_lo", 64'(a_ld_ready), 64'd0);
        chk("hold_core_reset", 64'(a_core_reset), 64'd1);
    endtask

    task automatic hold_to_run();
        tick();
        chk("hold2_core_reset", 64'(a_core_reset), 64'd1);
        tick();
        chk("run_core_reset", 64'(a_core_reset), 64'd0);
        chk("run_busy", 64'(a_busy), 64'd1);
        chk("run_cyc0", a_run_cycles, 64'd0);
    endtask

    // Feed NOPs, HALT on cycle halt_at (0 = never), for at most max_c RUN cycles.
    task automatic run(input int halt_at, input int max_c);
        for (int c = 1; c <= max_c; c++) begin
            chk("run_cnt", 64'(a_run_cycles), 64'(c - 1));
            core_instr = (c == halt_at) ? HALT : NOP;
            tick();
            if (c == halt_at) break;
        end
        core_instr = NOP;
    endtask

    task automatic wr_check(input int n);
        chk("wr_count", 64'(wr_a), 64'(n));
        chk("wr_drained", 64'(exp_a.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; abort = 0; ld_valid = 0; ld_last = 0; ld_data = 0; core_instr = NOP;
        b_start = 0; b_abort = 0; b_ld_valid = 0; b_ld_last = 0; b_ld_data = 0; b_core_instr = 0;
        repeat (2) tick();
        chk("rst_core_reset", 64'(a_core_reset), 64'd1);
        chk("rst_ld_ready", 64'(a_ld_ready), 64'd0);
        chk("rst_we", 64'(a_imem_we), 64'd0);
        chk("rst_addr", 64'(a_imem_addr), 64'd0);
        chk("rst_wdata", 64'(a_imem_wdata), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_error", 64'(a_error), 64'd0);
        chk("rst_run_cycles", a_run_cycles, 64'd0);
        rst = 1'b0;
        tick();

        // ld_valid outside LOAD is ignored
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        repeat (2) tick();
        chk("idle_busy", 64'(a_busy), 64'd0);
        chk("idle_no_we", 64'(a_imem_we), 64'd0);
        ld_valid = 1'b0;

        // T1 + T3: 4-word load, halt on 5th RUN cycle
        pulse_start();
        load(4, 1'b0);
        hold_to_run();
        run(5, 16);
        chk("t3_done", 64'(a_done), 64'd1);
        chk("t3_run_cycles", a_run_cycles, 64'd5);
        chk("t3_core_reset", 64'(a_core_reset), 64'd1);
        chk("t3_busy", 64'(a_busy), 64'd0);
        chk("t3_error", 64'(a_error), 64'd0);
        repeat (2) tick();
        chk("t3_frozen", a_run_cycles, 64'd5);
        wr_check(4);

        // T2 + T4: gapped load, then timeout
        pulse_start();
        chk("t2_run_cycles_kept", a_run_cycles, 64'd5);
        load(5, 1'b1);
        hold_to_run();
        run(0, 16);
        chk("t4_error", 64'(a_error), 64'd2);
        chk("t4_run_cycles", a_run_cycles, 64'd16);
        chk("t4_busy", 64'(a_busy), 64'd0);
        chk("t4_core_reset", 64'(a_core_reset), 64'd1);
        chk("t4_done", 64'(a_done), 64'd0);
        wr_check(9);

        // Restart clears error; halt coinciding with timeout ends in DONE
        pulse_start();
        load(1, 1'b0);
        hold_to_run();
        run(16, 16);
        chk("tie_done", 64'(a_done), 64'd1);
        chk("tie_error", 64'(a_error), 64'd0);
        chk("tie_run_cycles", a_run_cycles, 64'd16);
        wr_check(10);

        // T6: abort in RUN
        pulse_start();
        load(2, 1'b0);
        hold_to_run();
        run(0, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_core_reset", 64'(a_core_reset), 64'd1);
        chk("abort_ld_ready", 64'(a_ld_ready), 64'd0);
        chk("abort_done", 64'(a_done), 64'd0);
        chk("abort_error", 64'(a_error), 64'd0);
        tick();

        // abort in the same cycle as a handshake: no write
        pulse_start();
        ld_valid = 1'b1; ld_data = 32'h1234_5678; abort = 1'b1;
        tick();
        ld_valid = 1'b0; abort = 1'b0;
        chk("abort_ld_we", 64'(a_imem_we), 64'd0);
        chk("abort_ld_busy", 64'(a_busy), 64'd0);
        tick();
        wr_check(12);

        // Async reset mid-LOAD while a write is on the port
        pulse_start();
        ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
        exp_a.push_back({24'h0, 8'd0, ld_data});
        tick();
        ld_data = $urandom;
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 64'(a_imem_we), 64'd0);
        chk("arst_busy", 64'(a_busy), 64'd0);
        chk("arst_ld_ready", 64'(a_ld_ready), 64'd0);
        chk("arst_core_reset", 64'(a_core_reset), 64'd1);
        chk("arst_addr", 64'(a_imem_addr), 64'd0);
        chk("arst_run_cycles", a_run_cycles, 64'd0);
        ld_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle_we", 64'(a_imem_we), 64'd0);

        // Reload starts again at address 0
        pulse_start();
        load(2, 1'b0);
        hold_to_run();
        run(1, 16);
        chk("reload_done", 64'(a_done), 64'd1);
        chk("reload_run_cycles", a_run_cycles, 64'd1);
        tick();
        wr_check(15);

        // T5: 4-word memory, 5 words without last
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_busy", 64'(b_busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk("b_ovf_error", 64'(b_error), 64'd1);
                chk("b_ovf_ld_ready", 64'(b_ld_ready), 64'd0);
                chk("b_ovf_busy", 64'(b_busy), 64'd0);
            end
            b_ld_valid = 1'b1;
            b_ld_data  = $urandom;
            if (i < 4) exp_b.push_back({30'h0, 2'(i), b_ld_data});
            tick();
        end
        repeat (2) tick();
        b_ld_valid = 1'b0;
        tick();
        chk("b_wr_count", 64'(wr_b), 64'd4);
        chk("b_wr_drained", 64'(exp_b.size()), 64'd0);
        chk("b_last_addr", 64'(b_imem_addr), 64'd3);
        chk("b_error_kept", 64'(b_error), 64'd1);
        chk("b_core_reset", 64'(b_core_reset), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
